// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready-handshaked RV64-style ALU with optional iterative multiplier
//   Optional feature macro: ALU_MUL_EN (compiles in the radix-2 shift-add multiplier for code 1010)
//   Ports:
//     clk, rst_n            rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready     request handshake; in1, in2, alu_control captured on acceptance
//     out_valid/out_ready   result handshake; alu_result, zero_flag, illegal_op held until taken
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             illegal_op
);
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  state_t state;
  logic accept, is_mul, illegal;
  logic [WIDTH-1:0] res;
  logic [SHW-1:0] sh;
  assign in_ready  = (state == IDLE) || (state == OUT && out_ready);
  assign out_valid = state == OUT;
  assign accept    = in_valid && in_ready;
  assign sh        = in2[SHW-1:0];
  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (alu_control)
      4'b0000: res = in1 & in2;
      4'b0001: res = in1 | in2;
      4'b0010: res = in1 + in2;
      4'b0011: res = in1 ^ in2;
      4'b0100: res = in1 - in2;
      4'b0101: res = in1 << sh;
      4'b0110: res = in1 >> sh;
      4'b0111: res = $unsigned($signed(in1) >>> sh);
      4'b1000: res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      4'b1001: res = {{(WIDTH-1){1'b0}}, in1 < in2};
`ifdef ALU_MUL_EN
      4'b1010: res = '0;
`endif
      default: illegal = 1'b1;
    endcase
  end
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, acc, prod;
  logic [SHW-1:0] cnt;
  assign is_mul = alu_control == 4'b1010;
  // accumulator value after the current step; on the last step it is the final product
  assign prod   = acc + (mplier[0] ? mcand : '0);
`else
  assign is_mul = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_result <= '0;
      zero_flag  <= 1'b1;
      illegal_op <= 1'b0;
`ifdef ALU_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
`endif
    end else if (accept) begin
      if (is_mul) begin
        state <= MUL;
`ifdef ALU_MUL_EN
        mcand  <= in1;
        mplier <= in2;
        acc    <= '0;
        cnt    <= '0;
`endif
      end else begin
        state      <= OUT;
        alu_result <= res;
        zero_flag  <= res == '0;
        illegal_op <= illegal;
      end
    end else if (state == OUT && out_ready) begin
      state <= IDLE;
    end
`ifdef ALU_MUL_EN
    else if (state == MUL) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      // the WIDTH-th step lands on the edge that publishes the product
      if (cnt == SHW'(WIDTH - 1)) begin
        state      <= OUT;
        alu_result <= prod;
        zero_flag  <= prod == '0;
        illegal_op <= 1'b0;
      end
    end
`endif
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in1, in2;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_result;
  logic        zero_flag;
  logic        illegal_op;
  int checks = 0;
  int errors = 0;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    alu_control = op;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in1 = '0;
    in2 = '0;
    alu_control = '0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (alu_result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", alu_result); end
    checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero_flag); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [3:0]  ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
    logic [63:0] exp [6] = '{64'd2, 64'd63, 64'd65, 64'hFFFF_FFFF_FFFF_FFED, 64'd1, 64'd61};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 64'd23, 64'd42);
      checks++; if (out_valid !== 1'b1 || alu_result !== exp[i] || zero_flag !== 1'b0 || illegal_op !== 1'b0) begin
        errors++; $display("FAIL basic_op%0d got v=%b r=%h z=%b i=%b want v=1 r=%h z=0 i=0", i, out_valid, alu_result, zero_flag, illegal_op, exp[i]);
      end
    end
    drive(4'b1000, 64'd42, 64'd23);
    checks++; if (alu_result !== 64'd0 || zero_flag !== 1'b1) begin
      errors++; $display("FAIL slt_false got r=%h z=%b want r=0 z=1", alu_result, zero_flag);
    end
  endtask

  task automatic test_shifts();
    logic [63:0] a = 64'h8000_0000_0000_0000;
    drive(4'b0101, a, 64'h41);
    checks++; if (alu_result !== 64'd0 || zero_flag !== 1'b1) begin
      errors++; $display("FAIL sll got r=%h z=%b want r=0 z=1", alu_result, zero_flag);
    end
    drive(4'b0110, a, 64'h41);
    checks++; if (alu_result !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL srl got %h want 4000000000000000", alu_result);
    end
    drive(4'b0111, a, 64'h41);
    checks++; if (alu_result !== 64'hC000_0000_0000_0000) begin
      errors++; $display("FAIL sra got %h want c000000000000000", alu_result);
    end
    drive(4'b1001, a, 64'd1);
    checks++; if (alu_result !== 64'd0 || zero_flag !== 1'b1) begin
      errors++; $display("FAIL sltu got r=%h z=%b want r=0 z=1", alu_result, zero_flag);
    end
  endtask

  task automatic test_mul();
    int cyc = 0;
    int busy_bad = 0;
    out_ready = 1'b1;
    drive(4'b1010, 64'hFFFF_FFFF, 64'h1_0000_0001);
`ifdef ALU_MUL_EN
    while (!out_valid && cyc < 200) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (cyc !== 64) begin errors++; $display("FAIL mul_latency got %0d want 64", cyc); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL mul_in_ready got %0d ready cycles want 0", busy_bad); end
    checks++; if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFF || illegal_op !== 1'b0 || zero_flag !== 1'b0) begin
      errors++; $display("FAIL mul_result got r=%h z=%b i=%b want r=ffffffffffffffff z=0 i=0", alu_result, zero_flag, illegal_op);
    end
    drive(4'b1010, 64'd7, 64'd6);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (alu_result !== 64'd42 || cyc !== 64) begin
      errors++; $display("FAIL mul_small got r=%h lat=%0d want r=2a lat=64", alu_result, cyc);
    end
`else
    checks++; if (out_valid !== 1'b1 || alu_result !== 64'd0 || zero_flag !== 1'b1 || illegal_op !== 1'b1) begin
      errors++; $display("FAIL mul_disabled got v=%b r=%h z=%b i=%b want v=1 r=0 z=1 i=1", out_valid, alu_result, zero_flag, illegal_op);
    end
`endif
  endtask

  task automatic test_backpressure();
    idle_cycle();
    out_ready = 1'b0;
    drive(4'b0010, 64'd5, 64'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      alu_control = 4'b0000;
      in1 = 64'hFFFF;
      in2 = 64'h0;
      checks++; if (alu_result !== 64'd12 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold%0d got r=%h v=%b rdy=%b want r=c v=1 rdy=0", i, alu_result, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", in_ready); end
    drive(4'b0011, 64'hF, 64'h3);
    checks++; if (alu_result !== 64'hC || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_xor got r=%h v=%b want r=c v=1", alu_result, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    idle_cycle();
    out_ready = 1'b0;
`ifdef ALU_MUL_EN
    drive(4'b1010, 64'd3, 64'd5);
`else
    drive(4'b0010, 64'd1, 64'd1);
`endif
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 64'd0 || zero_flag !== 1'b1 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL abort got v=%b rdy=%b r=%h z=%b i=%b want v=0 rdy=1 r=0 z=1 i=0", out_valid, in_ready, alu_result, zero_flag, illegal_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulse got %0d want 0", pulses); end
  endtask

  task automatic test_illegal();
    drive(4'b1111, 64'h1234, 64'h5678);
    checks++; if (alu_result !== 64'd0 || zero_flag !== 1'b1 || illegal_op !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL illegal_1111 got r=%h z=%b i=%b v=%b want r=0 z=1 i=1 v=1", alu_result, zero_flag, illegal_op, out_valid);
    end
    drive(4'b1011, 64'hDEAD, 64'hBEEF);
    checks++; if (alu_result !== 64'd0 || illegal_op !== 1'b1) begin
      errors++; $display("FAIL illegal_1011 got r=%h i=%b want r=0 i=1", alu_result, illegal_op);
    end
    drive(4'b0001, 64'h1, 64'h2);
    checks++; if (alu_result !== 64'd3 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_clear got r=%h i=%b want r=3 i=0", alu_result, illegal_op);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shifts();
    test_mul();
    test_backpressure();
    test_reset_abort();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 64-bit combinational RV64 ALU. It registers every result and adds XOR, shift and unsigned-compare operations. It also adds an optional iterative multiplier that takes several cycles. It sits between the decode/operand-fetch stage and writeback, and decouples them through valid/ready handshakes on both sides.

## Interface
- WIDTH, 64, operand/result width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- alu_control  in  4  operation select
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- alu_result  out  WIDTH  registered result
- zero_flag  out  1  registered (alu_result == 0)
- illegal_op  out  1  registered; undefined alu_control was executed

## Operation
- Encodings (all ops single-cycle unless noted):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SUB
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 SLT (signed)
  - 1001 SLTU
  - 1010 MUL (low WIDTH bits of product, multi-cycle)
- Undefined codes 1011–1111:
  - result is 0, zero_flag is 1, illegal_op is 1.
  - They take the single-cycle path.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow output.
  - Shifts use in2[SHW-1:0] only.
  - SLT/SLTU results are zero-extended 0 or 1.
- A request is accepted when in_valid && in_ready. Operands and opcode are captured on that edge.
- State machine:
  - IDLE:
    - in_ready = 1.
    - Accepting a single-cycle op loads the result registers → OUT.
    - Accepting MUL loads the multiplicand, multiplier and accumulator, clears the step counter → MUL.
  - MUL:
    - in_ready = 0.
    - Radix-2 shift-add, one multiplier bit per cycle.
    - After WIDTH steps the accumulator loads into alu_result → OUT.
  - OUT:
    - out_valid = 1. alu_result, zero_flag and illegal_op are stable until handshake.
    - in_ready = out_ready.
    - On out_ready with no new request → IDLE.
    - On out_ready with a concurrent single-cycle request → new result loaded, stay in OUT.
    - On out_ready with a concurrent MUL request → MUL.
- in1, in2 and alu_control are ignored when not accepted.
- Asserting rst_n low mid-MUL or in OUT aborts the operation with no result delivered.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, alu_result = 0, zero_flag = 1, illegal_op = 0, state IDLE.
  - in_ready is combinational from state and out_ready.
- Single-cycle op latency: accepted at edge N → out_valid high after edge N (visible in cycle N+1).
- MUL latency: accepted at edge N → out_valid high after edge N+WIDTH (64 cycles for the default WIDTH).
- Throughput:
  - One single-cycle op per clock while out_ready is held high.
  - MUL blocks new input for WIDTH cycles.
- out_valid never drops without an out_ready handshake. Back-pressure holds all outputs frozen.
- The release of rst_n is synchronised externally; the block requires no timing beyond one clock edge after release.

## Configuration
- ALU_MUL_EN:
  - Defined: the multiplier datapath, counter and MUL state are compiled in, and 1010 behaves as specified.
  - Undefined: no multiplier logic, and 1010 is treated as an undefined code (result 0, zero_flag 1, illegal_op 1, single-cycle).

## Test plan
- Basic ops, out_ready tied 1, consecutive requests with A=23, B=42:
  - codes 0000/0001/0010/0100/1000 → results 2/63/65/−19 (0xFFFF_FFFF_FFFF_FFED)/1, each one cycle after acceptance.
  - Then A=42, B=23, code 1000 → 0 with zero_flag=1.
- Shifts, A=0x8000_0000_0000_0000, B=0x41 (shamt 1):
  - SLL → 0, zero_flag=1.
  - SRL → 0x4000_0000_0000_0000.
  - SRA → 0xC000_0000_0000_0000.
  - SLTU against B=1 → 0.
- MUL with ALU_MUL_EN defined, A=0xFFFF_FFFF, B=0x1_0000_0001:
  - in_ready is 0 for 64 cycles.
  - out_valid arrives 64 cycles after acceptance.
  - result is 0xFFFF_FFFF_FFFF_FFFF.
  - Without the macro: illegal_op=1, result 0, after 1 cycle.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after an ADD 5+7 → alu_result stays 12, out_valid stays 1, in_ready stays 0.
  - Raise out_ready together with in_valid (XOR 0xF^0x3) → next result 0xC the following cycle, with no bubble.
- Reset mid-MUL: pull rst_n low 10 cycles into a MUL → outputs return to reset values immediately, and no out_valid pulse follows.
- Undefined code 1111 with any operands → alu_result 0, zero_flag 1, illegal_op 1.
